// File: rtl/tkz_sched_ctrl.sv
// tkz_sched_ctrl: se/enc strobe sequencer for the masked TKz tweakey register.
// Drives LOAD -> RUN -> REVERT -> DONE across one SKINNY-128-384+ invocation
// and exposes round/phase counters plus a start/busy/done handshake.
// Optional build macro: TKZ_SCHED_CG_EN (cg_en = se | enc when defined, else 1).
module tkz_sched_ctrl #(
    parameter int unsigned ROUNDS      = 40,
    parameter int unsigned CPR         = 4,
    parameter int unsigned LOAD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       se,
    output logic       enc,
    output logic [5:0] round,
    output logic [2:0] phase,
    output logic       last_round,
    output logic       cg_en
);

    localparam int unsigned LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [5:0]     ROUND_LAST = 6'(ROUNDS - 1);
    localparam logic [2:0]     PHASE_LAST = 3'(CPR - 1);
    localparam logic [LCW-1:0] LOAD_LAST  = LCW'(LOAD_CYCLES - 1);
    localparam logic           ONE_ROUND  = (ROUNDS == 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        REVERT = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t         state_q;
    logic [LCW-1:0] load_cnt_q;
    logic [5:0]     round_q;
    logic [2:0]     phase_q;
    logic           busy_q;
    logic           done_q;
    logic           se_q;
    logic           enc_q;
    logic           last_q;

    // Next-cycle incremented counters, used for wrap and strobe look-ahead.
    logic [5:0] round_inc;
    logic [2:0] phase_inc;
    assign round_inc = 6'(round_q + 6'd1);
    assign phase_inc = 3'(phase_q + 3'd1);

    // FSM: state, counters and registered outputs for the state being entered.
    always_ff @(posedge clk) begin
        if (rst || (abort && state_q != IDLE)) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            round_q    <= '0;
            phase_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            se_q       <= 1'b0;
            enc_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD;
                        load_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        se_q       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_cnt_q == LOAD_LAST) begin
                        state_q <= RUN;
                        round_q <= '0;
                        phase_q <= '0;
                        se_q    <= 1'b0;
                        enc_q   <= 1'b0;
                        last_q  <= ONE_ROUND;
                    end else begin
                        load_cnt_q <= LCW'(load_cnt_q + LCW'(1));
                    end
                end
                RUN: begin
                    if (phase_q == PHASE_LAST) begin
                        enc_q <= 1'b0;
                        if (round_q == ROUND_LAST) begin
                            // Round index holds at its final value through REVERT/DONE.
                            state_q <= REVERT;
                            se_q    <= 1'b1;
                            last_q  <= 1'b0;
                        end else begin
                            round_q <= round_inc;
                            phase_q <= '0;
                            last_q  <= (round_inc == ROUND_LAST);
                        end
                    end else begin
                        phase_q <= phase_inc;
                        enc_q   <= (phase_inc == PHASE_LAST);
                    end
                end
                REVERT: begin
                    state_q <= DONE;
                    se_q    <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    round_q <= '0;
                    phase_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    se_q    <= 1'b0;
                    enc_q   <= 1'b0;
                    last_q  <= 1'b0;
                    round_q <= '0;
                    phase_q <= '0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign se         = se_q;
    assign enc        = enc_q;
    assign round      = round_q;
    assign phase      = phase_q;
    assign last_round = last_q;

    // TKz clock enable: gated variant only clocks on cycles where TKz changes.
`ifdef TKZ_SCHED_CG_EN
    assign cg_en = se_q | enc_q;
`else
    assign cg_en = 1'b1;
`endif

endmodule

// File: tb/tb_tkz_sched_ctrl.sv
// Self-checking bench for tkz_sched_ctrl: default-parameter instance plus a
// minimal ROUNDS=1/CPR=2/LOAD_CYCLES=1 instance, both tracked by a
// cycles-since-start reference model.
module tb_tkz_sched_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic b_start, b_abort, s_start, s_abort;
    logic b_busy, b_done, b_se, b_enc, b_last, b_cg;
    logic s_busy, s_done, s_se, s_enc, s_last, s_cg;
    logic [5:0] b_round, s_round;
    logic [2:0] b_phase, s_phase;

    tkz_sched_ctrl u_big (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .busy(b_busy), .done(b_done), .se(b_se), .enc(b_enc),
        .round(b_round), .phase(b_phase), .last_round(b_last), .cg_en(b_cg)
    );

    tkz_sched_ctrl #(.ROUNDS(1), .CPR(2), .LOAD_CYCLES(1)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
        .busy(s_busy), .done(s_done), .se(s_se), .enc(s_enc),
        .round(s_round), .phase(s_phase), .last_round(s_last), .cg_en(s_cg)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int t_big = 0;
    int t_small = 0;

    typedef struct {
        int busy, se, enc, done, last, round, phase;
        bit chk_round, chk_phase;
    } exp_t;

    // Expected outputs from the number of cycles elapsed since start was taken (0 = idle).
    function automatic exp_t model(int t, int L, int R, int C);
        exp_t e;
        int rc, k;
        bit run;
        rc  = R * C;
        run = (t > L) && (t <= L + rc);
        k   = t - L - 1;
        e.busy  = (t != 0) ? 1 : 0;
        e.se    = ((t >= 1 && t <= L) || t == L + rc + 1) ? 1 : 0;
        e.enc   = (run && (k % C) == C - 1) ? 1 : 0;
        e.done  = (t == L + rc + 2) ? 1 : 0;
        e.round = run ? k / C : ((t == L + rc + 1) ? R - 1 : 0);
        e.phase = run ? k % C : 0;
        e.last  = (run && (k / C) == R - 1) ? 1 : 0;
        e.chk_round = (t == 0) || run || (t == L + rc + 1);
        e.chk_phase = (t == 0) || run;
        return e;
    endfunction

    function automatic int advance(int t, bit r, bit st, bit ab, int lat);
        if (r) return 0;
        if (ab && t != 0) return 0;
        if (t == 0) return st ? 1 : 0;
        if (t == lat) return 0;
        return t + 1;
    endfunction

    task automatic chk(string nm, int act, int expv);
        nchk++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic check_dut(string tag, exp_t e, logic bu, logic dn, logic s, logic en,
                             logic [5:0] rd, logic [2:0] ph, logic ls, logic cg);
        int cg_exp;
`ifdef TKZ_SCHED_CG_EN
        cg_exp = e.se | e.enc;
`else
        cg_exp = 1;
`endif
        chk({tag, ".busy"}, int'(bu), e.busy);
        chk({tag, ".done"}, int'(dn), e.done);
        chk({tag, ".se"}, int'(s), e.se);
        chk({tag, ".enc"}, int'(en), e.enc);
        chk({tag, ".last_round"}, int'(ls), e.last);
        chk({tag, ".cg_en"}, int'(cg), cg_exp);
        chk({tag, ".se_and_enc"}, int'(s & en), 0);
        if (e.chk_round) chk({tag, ".round"}, int'(rd), e.round);
        if (e.chk_phase) chk({tag, ".phase"}, int'(ph), e.phase);
    endtask

    // One clock: advance the model with the applied inputs, then compare away from the edge.
    task automatic step();
        @(posedge clk);
        t_big   = advance(t_big, rst, b_start, b_abort, 2 + 40 * 4 + 2);
        t_small = advance(t_small, rst, s_start, s_abort, 1 + 1 * 2 + 2);
        #1;
        cyc++;
        check_dut("big", model(t_big, 2, 40, 4), b_busy, b_done, b_se, b_enc,
                  b_round, b_phase, b_last, b_cg);
        check_dut("small", model(t_small, 1, 1, 2), s_busy, s_done, s_se, s_enc,
                  s_round, s_phase, s_last, s_cg);
    endtask

    typedef struct {
        logic rst, start, abort;
        int busy, se, enc, done, last;
    } vec_t;

    vec_t vt[13];

    initial begin
        int enc_cnt, done_at, se_cnt, prev_done, gap_ok, ndone;

        // Directed table for the minimal instance: reset hold, full invocation, abort.
        vt[0]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        vt[3]  = '{0, 1, 0, 1, 1, 0, 0, 0};
        vt[4]  = '{0, 0, 0, 1, 0, 0, 0, 1};
        vt[5]  = '{0, 0, 0, 1, 0, 1, 0, 1};
        vt[6]  = '{0, 0, 0, 1, 1, 0, 0, 0};
        vt[7]  = '{0, 0, 0, 1, 0, 0, 1, 0};
        vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        vt[9]  = '{0, 1, 0, 1, 1, 0, 0, 0};
        vt[10] = '{0, 0, 1, 0, 0, 0, 0, 0};
        vt[11] = '{0, 0, 1, 0, 0, 0, 0, 0};
        vt[12] = '{0, 1, 0, 1, 1, 0, 0, 0};

        rst = 1'b1; b_start = 1'b1; b_abort = 1'b0; s_start = 1'b1; s_abort = 1'b0;
        for (int i = 0; i < 13; i++) begin
            rst = vt[i].rst; s_start = vt[i].start; s_abort = vt[i].abort;
            b_start = (i < 3) ? 1'b1 : 1'b0;
            step();
            chk("tbl.busy", int'(s_busy), vt[i].busy);
            chk("tbl.se", int'(s_se), vt[i].se);
            chk("tbl.enc", int'(s_enc), vt[i].enc);
            chk("tbl.done", int'(s_done), vt[i].done);
            chk("tbl.last", int'(s_last), vt[i].last);
        end
        s_start = 1'b0; s_abort = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Single default invocation: se at 1-2 and 163, enc count, done at 164, last_round 159-162.
        b_start = 1'b1;
        enc_cnt = 0; done_at = -1; se_cnt = 0;
        for (int c = 1; c <= 170; c++) begin
            step();
            b_start = 1'b0;
            if (b_enc) enc_cnt++;
            if (b_se) se_cnt++;
            if (b_done && done_at < 0) done_at = c;
            if (c == 163) chk("seq.revert_round", int'(b_round), 39);
            if (c == 159 || c == 162) chk("seq.last_round", int'(b_last), 1);
            if (c == 158) chk("seq.last_round_pre", int'(b_last), 0);
        end
        chk("seq.enc_count", enc_cnt, 40);
        chk("seq.se_count", se_cnt, 3);
        chk("seq.done_cycle", done_at, 164);

        // Abort at cycle 50: idle at 51, no revert se or done afterwards.
        b_start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            step();
            b_start = 1'b0;
        end
        b_abort = 1'b1;
        step();
        b_abort = 1'b0;
        chk("abort.busy", int'(b_busy), 0);
        se_cnt = 0; done_at = 0;
        for (int c = 0; c < 150; c++) begin
            step();
            if (b_se) se_cnt++;
            if (b_done) done_at++;
        end
        chk("abort.no_se", se_cnt, 0);
        chk("abort.no_done", done_at, 0);

        // Fresh invocation after abort, then start held high for back-to-back runs.
        b_start = 1'b1;
        prev_done = -1; gap_ok = 0; ndone = 0;
        for (int c = 1; c <= 3 * 165 + 5; c++) begin
            step();
            if (b_done) begin
                if (ndone == 0) chk("b2b.first_done", c, 164);
                else chk("b2b.gap", c - prev_done, 165);
                prev_done = c;
                ndone++;
            end
        end
        chk("b2b.done_count", ndone, 3);
        b_start = 1'b0;

        // Randomized traffic on both instances, checked every cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            rst     = (($urandom % 700) == 0);
            b_start = (($urandom % 4) == 0);
            b_abort = (($urandom % 300) == 0);
            s_start = (($urandom % 3) == 0);
            s_abort = (($urandom % 20) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/tkz_sched_ctrl.md
# tkz_sched_ctrl

Sequencing controller for the masked 64-bit TKz tweakey register in the Romulus-N third-order core. It generates the `se` (load/revert) and `enc` (round update) strobes that drive both 32-bit halves of the TKz register across a SKINNY-128-384+ invocation. It also exposes round/phase counters to the round datapath and a start/busy/done handshake to the mode controller. It is a pure control block and contains no tweakey data.

## Interface
Parameters:
- `ROUNDS`, 40: SKINNY rounds per invocation; legal range 1..64.
- `CPR`, 4: cycles per round on the 32-bit datapath; legal range 2..8.
- `LOAD_CYCLES`, 2: cycles of `se` at invocation start, one per 32-bit half.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a new invocation; sampled only in IDLE.
- `abort`  in  1: cancel the current invocation.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at the end of an invocation.
- `se`  out  1: TKz register loads its `si` (revert) input.
- `enc`  out  1: TKz register loads its `skinny_tkz` input.
- `round`  out  6: current round index, 0..ROUNDS-1.
- `phase`  out  3: cycle within the round, 0..CPR-1.
- `last_round`  out  1: high when `round == ROUNDS-1` and the state is RUN.
- `cg_en`  out  1: clock-gate enable for the TKz register (see Configuration).

## Operation
- Moore FSM with states IDLE, LOAD, RUN, REVERT, DONE. All outputs decode from registered state and counters only.
- **IDLE**
  - `busy`, `se`, `enc`, `done` = 0; `round` = 0; `phase` = 0.
  - `start=1` moves to LOAD.
- **LOAD**
  - `se=1` for exactly LOAD_CYCLES cycles; a load counter tracks them.
  - Then moves to RUN with `round=0`, `phase=0`.
- **RUN**
  - `phase` increments every cycle and wraps from CPR-1 to 0.
  - On each wrap, `round` increments.
  - `enc=1` only when `phase == CPR-1`, giving exactly one tweakey update per round.
  - Leaves for REVERT at `round == ROUNDS-1 && phase == CPR-1`; `round` does not wrap to 0.
- **REVERT**
  - `se=1` for one cycle, restoring TKz to its pre-invocation value for the next block.
  - Then moves to DONE.
- **DONE**
  - `done=1` and `busy=1` for one cycle, then moves to IDLE.
- Invariant: `se` and `enc` are never high in the same cycle.
- `start` while busy is ignored; it is not queued.
- `abort=1` in any non-IDLE state moves to IDLE on the next edge with counters cleared. No REVERT and no `done` follow.
- `abort` has priority over all other transitions. `abort` in IDLE has no effect.
- `rst` has priority over `abort` and `start`.
- `rst` mid-invocation gives the same result as abort, with all outputs at reset values on the following cycle.

## Timing
- Reset values: `busy=0`, `done=0`, `se=0`, `enc=0`, `round=0`, `phase=0`, `last_round=0`, state IDLE.
- `start` is sampled at edge k. Cycles are numbered after edge k, with defaults:
  - cycles 1–2: LOAD, `se=1`.
  - cycles 3–162: RUN.
  - `enc=1` in cycles 6, 10, …, 162, i.e. 40 pulses.
  - cycle 163: REVERT, `se=1`.
  - cycle 164: `done=1`.
  - cycle 165: IDLE.
- General latency from `start` to `done`: LOAD_CYCLES + ROUNDS·CPR + 2 cycles.
- Back-to-back invocations: `start` held high is accepted at the IDLE edge. The minimum gap between consecutive `done` pulses is the latency + 1.
- `round`/`phase` counter widths are fixed at 6/3 bits. There is no overflow by construction within the legal parameter ranges.

## Configuration
- Macro `TKZ_SCHED_CG_EN`.
- **Defined:** `cg_en = se | enc`. The TKz register clock is enabled only in cycles where it changes, for the clock-gated register variant.
- **Undefined:** `cg_en` is tied to 1, for the non-gated register variant that holds through its own enables.
- FSM behaviour and all other outputs are identical in both builds.

## Test plan
1. **Reset hold:** `rst=1` for 3 cycles with `start=1` -> all outputs 0, state IDLE, no `se`/`enc`.
2. **Single invocation, defaults:** `start` pulse at edge k ->
   - `se` high in cycles 1–2 and 163.
   - exactly 40 `enc` pulses, at cycles 6+4n.
   - `done` only at cycle 164.
   - `se&enc` never high together.
3. **Counters and round boundary:** during RUN, `round`/`phase` step 0..39 / 0..3; `last_round` high only in cycles 159–162; at cycle 163 `round` stays 39.
4. **Abort mid-run:** `abort` at cycle 50 -> IDLE at cycle 51, `busy=0`, no REVERT `se`, no `done`. A subsequent `start` produces a full, normal invocation.
5. **Start while busy and back-to-back:** `start` held high continuously ->
   - pulses during busy are ignored.
   - `done` pulses are 165 cycles apart.
6. **Parameter and macro sweep:** `ROUNDS=1`, `CPR=2`, `LOAD_CYCLES=1` -> `done` at cycle 5. With `TKZ_SCHED_CG_EN` defined, `cg_en == se|enc` every cycle; undefined, `cg_en == 1` every cycle.
